// File: rtl/p_hit_pkg.sv
// Shared types, defaults and fixed-point helpers for the ray/plane hit-point unit.
package p_hit_pkg;

  localparam int unsigned Q_BITS_DEFAULT     = 16;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned FIXED_W            = 32;
  localparam int unsigned VEC_W              = 3 * FIXED_W;
  localparam int unsigned N_IN               = 4;
  localparam int unsigned PIPE_STAGES        = 5;

  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef fixed_t [2:0] vec3_t;

  // Input FIFO slots, in in_wr_en / in_full bit order.
  typedef enum logic [1:0] {
    IN_ORIGIN_1 = 2'd0,
    IN_ORIGIN_2 = 2'd1,
    IN_DIR_1    = 2'd2,
    IN_DIR_2    = 2'd3
  } in_fifo_e;

  // One operand set popped from the four input FIFOs together.
  typedef struct packed {
    vec3_t origin_1;
    vec3_t origin_2;
    vec3_t dir_1;
    vec3_t dir_2;
  } ray_t;

  // Full 64-bit signed product, rescaled by q fractional bits, truncated to 32.
  function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b, input int unsigned q);
    logic signed [2*FIXED_W-1:0] a_x;
    logic signed [2*FIXED_W-1:0] b_x;
    logic signed [2*FIXED_W-1:0] prod;
    logic signed [2*FIXED_W-1:0] scaled;
    a_x    = {{FIXED_W{a[FIXED_W-1]}}, a};
    b_x    = {{FIXED_W{b[FIXED_W-1]}}, b};
    prod   = a_x * b_x;
    scaled = prod >>> q;
    return scaled[FIXED_W-1:0];
  endfunction

endpackage

// File: rtl/p_hit_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty/count flags.
module p_hit_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         full,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data_c,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr_c;
  logic             do_rd_c;
  logic [CW-1:0]    count_nxt_c;

  // Writes while full and reads while empty are ignored.
  always_comb begin
    do_wr_c     = wr_en && !full;
    do_rd_c     = rd_en && !empty;
    count_nxt_c = count;
    if (do_wr_c && !do_rd_c) begin
      count_nxt_c = count + CW'(1);
    end else if (!do_wr_c && do_rd_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/p_hit.sv
// Ray/plane hit point P = origin_2 + t*dir_2, t = dot(n1, v0-origin_1) / dot(n2, dir_1).
module p_hit
  import p_hit_pkg::*;
#(
  parameter int unsigned Q_BITS     = Q_BITS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0][31:0] tri_normal_1,
  input  logic [2:0][31:0] tri_normal_2,
  input  logic [2:0][31:0] v0,
  input  logic [2:0][31:0] origin_1,
  input  logic [2:0][31:0] origin_2,
  input  logic [2:0][31:0] dir_1,
  input  logic [2:0][31:0] dir_2,
  input  logic [3:0]       in_wr_en,
  output logic [3:0]       in_full,
  output logic [2:0][31:0] out,
  input  logic             out_rd_en,
  output logic             out_empty
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CW + 1;
  localparam int unsigned INF_W = $clog2(PIPE_STAGES + 1);
  localparam int unsigned DIV_W = FIXED_W + Q_BITS;

  logic [N_IN-1:0][VEC_W-1:0] in_wdata;
  logic [N_IN-1:0][VEC_W-1:0] in_head;
  logic [N_IN-1:0]            in_empty;
  logic [N_IN-1:0][CW-1:0]    in_count_unused;
  logic [CW-1:0]              out_count;
  logic                       out_full_unused;

  logic                       issue_c;
  logic [INF_W-1:0]           inflight_c;
  logic [OCC_W-1:0]           occupancy_c;
  ray_t                       head_ray_c;

  // Pipeline registers; s0 holds the popped operand set and sampled statics.
  logic   s0_vld, s1_vld, s2_vld, s3_vld, s4_vld;
  ray_t   s0_ray;
  vec3_t  s0_n1, s0_n2, s0_v0;
  vec3_t  s1_diff, s1_n1, s1_n2, s1_dir_1, s1_origin_2, s1_dir_2;
  fixed_t s2_num, s2_den;
  vec3_t  s2_origin_2, s2_dir_2;
  fixed_t s3_t;
  vec3_t  s3_origin_2, s3_dir_2;
  vec3_t  s4_p;

  vec3_t                    diff_c;
  fixed_t                   num_c;
  fixed_t                   den_c;
  logic signed [DIV_W-1:0]  dividend_c;
  logic signed [DIV_W-1:0]  divisor_c;
  logic signed [DIV_W-1:0]  quotient_c;
  fixed_t                   t_c;
  vec3_t                    p_c;

  assign in_wdata[IN_ORIGIN_1] = origin_1;
  assign in_wdata[IN_ORIGIN_2] = origin_2;
  assign in_wdata[IN_DIR_1]    = dir_1;
  assign in_wdata[IN_DIR_2]    = dir_2;

  for (genvar i = 0; i < N_IN; i++) begin : g_in_fifo
    p_hit_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (in_wr_en[i]),
      .wr_data   (in_wdata[i]),
      .full      (in_full[i]),
      .rd_en     (issue_c),
      .rd_data_c (in_head[i]),
      .empty     (in_empty[i]),
      .count     (in_count_unused[i])
    );
  end

  // Issue only when every result already queued or in flight has an output slot.
  always_comb begin
    inflight_c  = INF_W'(s0_vld) + INF_W'(s1_vld) + INF_W'(s2_vld)
                + INF_W'(s3_vld) + INF_W'(s4_vld);
    occupancy_c = OCC_W'(out_count) + OCC_W'(inflight_c);
    issue_c     = (in_empty == '0) && (occupancy_c < OCC_W'(FIFO_DEPTH));
    head_ray_c          = '0;
    head_ray_c.origin_1 = in_head[IN_ORIGIN_1];
    head_ray_c.origin_2 = in_head[IN_ORIGIN_2];
    head_ray_c.dir_1    = in_head[IN_DIR_1];
    head_ray_c.dir_2    = in_head[IN_DIR_2];
  end

  // Stage datapaths: difference, dot products, divide, final scale-and-add.
  always_comb begin
    diff_c = '0;
    num_c  = '0;
    den_c  = '0;
    p_c    = '0;
    for (int k = 0; k < 3; k++) begin
      diff_c[k] = s0_v0[k] - s0_ray.origin_1[k];
      num_c     = num_c + fx_mul(s1_n1[k], s1_diff[k], Q_BITS);
      den_c     = den_c + fx_mul(s1_n2[k], s1_dir_1[k], Q_BITS);
      p_c[k]    = s3_origin_2[k] + fx_mul(s3_t, s3_dir_2[k], Q_BITS);
    end
    dividend_c = {s2_num, {Q_BITS{1'b0}}};
    divisor_c  = {{Q_BITS{s2_den[FIXED_W-1]}}, s2_den};
    quotient_c = '0;
    t_c        = '0;
    if (s2_den != '0) begin
      quotient_c = dividend_c / divisor_c;
      t_c        = quotient_c[FIXED_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_vld      <= 1'b0;
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      s3_vld      <= 1'b0;
      s4_vld      <= 1'b0;
      s0_ray      <= '0;
      s0_n1       <= '0;
      s0_n2       <= '0;
      s0_v0       <= '0;
      s1_diff     <= '0;
      s1_n1       <= '0;
      s1_n2       <= '0;
      s1_dir_1    <= '0;
      s1_origin_2 <= '0;
      s1_dir_2    <= '0;
      s2_num      <= '0;
      s2_den      <= '0;
      s2_origin_2 <= '0;
      s2_dir_2    <= '0;
      s3_t        <= '0;
      s3_origin_2 <= '0;
      s3_dir_2    <= '0;
      s4_p        <= '0;
    end else begin
      s0_vld      <= issue_c;
      s0_ray      <= head_ray_c;
      s0_n1       <= tri_normal_1;
      s0_n2       <= tri_normal_2;
      s0_v0       <= v0;

      s1_vld      <= s0_vld;
      s1_diff     <= diff_c;
      s1_n1       <= s0_n1;
      s1_n2       <= s0_n2;
      s1_dir_1    <= s0_ray.dir_1;
      s1_origin_2 <= s0_ray.origin_2;
      s1_dir_2    <= s0_ray.dir_2;

      s2_vld      <= s1_vld;
      s2_num      <= num_c;
      s2_den      <= den_c;
      s2_origin_2 <= s1_origin_2;
      s2_dir_2    <= s1_dir_2;

      s3_vld      <= s2_vld;
      s3_t        <= t_c;
      s3_origin_2 <= s2_origin_2;
      s3_dir_2    <= s2_dir_2;

      s4_vld      <= s3_vld;
      s4_p        <= p_c;
    end
  end

  p_hit_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (s4_vld),
    .wr_data   (s4_p),
    .full      (out_full_unused),
    .rd_en     (out_rd_en),
    .rd_data_c (out),
    .empty     (out_empty),
    .count     (out_count)
  );

endmodule

// File: tb/tb_p_hit.sv
// Bench for p_hit: queue-level reference model checked every cycle plus directed literal checks.
module tb_p_hit;

  localparam int DEPTH = 16;
  localparam int LAT   = 5;

  logic             clock;
  logic             reset;
  logic [2:0][31:0] tri_normal_1, tri_normal_2, v0;
  logic [2:0][31:0] origin_1, origin_2, dir_1, dir_2;
  logic [3:0]       in_wr_en;
  logic [3:0]       in_full;
  logic [2:0][31:0] out;
  logic             out_rd_en;
  logic             out_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  p_hit dut (
    .clock        (clock),
    .reset        (reset),
    .tri_normal_1 (tri_normal_1),
    .tri_normal_2 (tri_normal_2),
    .v0           (v0),
    .origin_1     (origin_1),
    .origin_2     (origin_2),
    .dir_1        (dir_1),
    .dir_2        (dir_2),
    .in_wr_en     (in_wr_en),
    .in_full      (in_full),
    .out          (out),
    .out_rd_en    (out_rd_en),
    .out_empty    (out_empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] v3(input int x, input int y, input int z);
    return {z, y, x};
  endfunction

  // Reference: the hit-point rules evaluated with plain 64-bit integer arithmetic.
  function automatic logic [95:0] hit_point(input logic [95:0] o1, input logic [95:0] o2,
                                            input logic [95:0] d1, input logic [95:0] d2,
                                            input logic [95:0] n1, input logic [95:0] n2,
                                            input logic [95:0] vv);
    longint num, den, q;
    int t, a, b;
    logic [95:0] res;
    num = 0;
    den = 0;
    for (int k = 0; k < 3; k++) begin
      a = n1[32*k +: 32];
      b = vv[32*k +: 32] - o1[32*k +: 32];
      num += (longint'(a) * longint'(b)) >>> 16;
      a = n2[32*k +: 32];
      b = d1[32*k +: 32];
      den += (longint'(a) * longint'(b)) >>> 16;
    end
    num = longint'(int'(num));
    den = longint'(int'(den));
    if (den == 0) t = 0;
    else begin
      q = (num * 65536) / den;
      t = int'(q);
    end
    for (int k = 0; k < 3; k++) begin
      a = o2[32*k +: 32];
      b = d2[32*k +: 32];
      res[32*k +: 32] = a + int'((longint'(t) * longint'(b)) >>> 16);
    end
    return res;
  endfunction

  logic [95:0] q_o1[$], q_o2[$], q_d1[$], q_d2[$];
  logic [95:0] m_out[$];
  logic [95:0] m_pres[$];
  int          m_plat[$];

  // Queue-level model: input queues, a fixed-latency in-flight list, output queue.
  always @(posedge clock or negedge reset) begin : model_step
    logic [3:0]  acc;
    bit          iss;
    bit          rd;
    logic [95:0] r;
    if (!reset) begin
      q_o1.delete(); q_o2.delete(); q_d1.delete(); q_d2.delete();
      m_out.delete(); m_pres.delete(); m_plat.delete();
    end else begin
      acc[0] = in_wr_en[0] && (q_o1.size() < DEPTH);
      acc[1] = in_wr_en[1] && (q_o2.size() < DEPTH);
      acc[2] = in_wr_en[2] && (q_d1.size() < DEPTH);
      acc[3] = in_wr_en[3] && (q_d2.size() < DEPTH);
      iss = (q_o1.size() > 0) && (q_o2.size() > 0) && (q_d1.size() > 0) && (q_d2.size() > 0)
            && ((m_out.size() + m_pres.size()) < DEPTH);
      rd = out_rd_en && (m_out.size() > 0);
      if (rd) void'(m_out.pop_front());
      for (int i = 0; i < m_plat.size(); i++) m_plat[i] = m_plat[i] - 1;
      if (m_plat.size() > 0 && m_plat[0] == 0) begin
        m_out.push_back(m_pres.pop_front());
        void'(m_plat.pop_front());
      end
      if (iss) begin
        r = hit_point(q_o1.pop_front(), q_o2.pop_front(), q_d1.pop_front(), q_d2.pop_front(),
                      tri_normal_1, tri_normal_2, v0);
        m_pres.push_back(r);
        m_plat.push_back(LAT);
      end
      if (acc[0]) q_o1.push_back(origin_1);
      if (acc[1]) q_o2.push_back(origin_2);
      if (acc[2]) q_d1.push_back(dir_1);
      if (acc[3]) q_d2.push_back(dir_2);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("model_out_empty", 96'(out_empty), 96'(m_out.size() == 0));
      check("model_in_full", 96'(in_full),
            96'({q_d2.size() == DEPTH, q_d1.size() == DEPTH,
                 q_o2.size() == DEPTH, q_o1.size() == DEPTH}));
      if (m_out.size() > 0) check("model_out_head", out, m_out[0]);
    end
  end

  task automatic put(input logic [3:0] en, input logic [95:0] o1, input logic [95:0] o2,
                     input logic [95:0] d1, input logic [95:0] d2);
    origin_1 = o1;
    origin_2 = o2;
    dir_1    = d1;
    dir_2    = d2;
    in_wr_en = en;
    @(negedge clock);
    in_wr_en = 4'h0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (out_empty && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, 96'(out_empty), 96'(0));
  endtask

  task automatic pop_one();
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
  endtask

  task automatic drain(input int cycles, output int popped);
    popped = 0;
    out_rd_en = 1'b1;
    repeat (cycles) begin
      if (!out_empty) popped++;
      @(negedge clock);
    end
    out_rd_en = 1'b0;
  endtask

  task automatic set_axis_statics();
    tri_normal_1 = v3(0, 0, 32'h0001_0000);
    tri_normal_2 = v3(0, 0, 32'h0001_0000);
    v0           = v3(0, 0, 32'h0005_0000);
  endtask

  initial begin
    int edges;
    int popped;
    reset = 1'b0;
    in_wr_en = 4'h0;
    out_rd_en = 1'b0;
    origin_1 = '0; origin_2 = '0; dir_1 = '0; dir_2 = '0;
    set_axis_statics();
    @(negedge clock);
    check("reset_out_empty", 96'(out_empty), 96'(1));
    check("reset_in_full", 96'(in_full), 96'(0));
    check("reset_out", out, 96'(0));
    reset = 1'b1;
    @(negedge clock);

    // Axis hit with latency measured from the pop edge (one edge after the write edge).
    put(4'hF, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 32'h0001_0000), v3(0, 0, 32'h0001_0000));
    edges = 1;
    while (out_empty && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    check("axis_latency_after_pop", 96'(edges - 2), 96'(5));
    check("axis_out", out, v3(0, 0, 32'h0005_0000));
    pop_one();

    put(4'hF, v3(0, 0, 0), v3(0, 0, 0), v3(32'h0001_0000, 0, 32'h0001_0000),
        v3(32'h0001_0000, 0, 32'h0001_0000));
    wait_result("oblique_wait");
    check("oblique_out", out, v3(32'h0005_0000, 0, 32'h0005_0000));
    pop_one();

    put(4'hF, v3(0, 0, 0), v3(32'h0002_0000, 32'h0003_0000, 0), v3(32'h0001_0000, 0, 0),
        v3(32'h0001_0000, 0, 0));
    wait_result("parallel_wait");
    check("parallel_out", out, v3(32'h0002_0000, 32'h0003_0000, 0));
    pop_one();
    repeat (2) @(negedge clock);

    // Stream of 40 rays with no reads: 16 results + 16 queued, rest dropped.
    tri_normal_1 = v3(32'h0000_8000, 32'h0000_4000, 32'h0001_0000);
    tri_normal_2 = v3(32'h0000_4000, 32'h0001_0000, 32'h0000_8000);
    v0           = v3(32'h0003_0000, 32'h0002_0000, 32'h0005_0000);
    for (int i = 0; i < 40; i++) begin
      put(4'hF, v3(i * 32'h1000, -i * 32'h800, i * 32'h100),
          v3(i, i * 32'h200, 32'h0001_0000),
          v3(32'h0001_0000 + i * 32'h200, (i % 5) * 32'h4000 - 32'h8000, 32'h0002_0000),
          v3(-i * 32'h300, 32'h8000, i * 32'h1000));
    end
    repeat (10) @(negedge clock);
    check("stream_in_full", 96'(in_full), 96'(4'hF));
    check("stream_out_ready", 96'(out_empty), 96'(0));
    drain(60, popped);
    check("stream_pop_count", 96'(popped), 96'(32));
    check("stream_drained_empty", 96'(out_empty), 96'(1));

    // Only three of four FIFOs written: nothing may issue until the fourth arrives.
    set_axis_statics();
    put(4'b0111, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 32'h0001_0000), v3(0, 0, 32'h0001_0000));
    repeat (10) @(negedge clock);
    check("partial_no_issue", 96'(out_empty), 96'(1));
    put(4'b1000, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 32'h0001_0000), v3(0, 0, 32'h0001_0000));
    drain(20, popped);
    check("partial_one_result", 96'(popped), 96'(1));

    // Reset with data queued and in flight.
    for (int i = 0; i < 20; i++) begin
      put(4'hF, v3(i, 0, 0), v3(0, i * 32'h1_0000, 0), v3(0, 0, 32'h0001_0000),
          v3(0, 0, 32'h0001_0000));
    end
    #2;
    reset = 1'b0;
    #1;
    check("midreset_out_empty", 96'(out_empty), 96'(1));
    check("midreset_in_full", 96'(in_full), 96'(0));
    check("midreset_out", out, 96'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    put(4'hF, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 32'h0001_0000), v3(0, 0, 32'h0001_0000));
    wait_result("post_reset_wait");
    check("post_reset_out", out, v3(0, 0, 32'h0005_0000));
    pop_one();
    repeat (8) @(negedge clock);
    check("post_reset_no_stale", 96'(out_empty), 96'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/p_hit.md
Name: p_hit

Overview:
- Ray/plane hit-point unit: computes P = origin + t*dir, where t = dot(n, v0 - origin) / dot(n, dir).
- All values are signed fixed point with Q_BITS fractional bits.
- Sits after the triangle-normal stage of the ray tracer. Per-ray data (origins, directions) arrives through four input FIFOs; triangle normals and v0 are quasi-static inputs.
- Results leave through one show-ahead output FIFO.

Parameters:
- Q_BITS, 16, number of fractional bits of every fixed-point operand and result.
- FIFO_DEPTH, 16, depth of each input FIFO and of the output FIFO (power of two).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tri_normal_1[2:0]  in  3x32 signed  normal used in the numerator dot product; static, must be held stable.
- tri_normal_2[2:0]  in  3x32 signed  normal used in the denominator dot product; static.
- v0[2:0]  in  3x32 signed  triangle vertex 0; static.
- origin_1[2:0]  in  3x32 signed  write data for FIFO 0 (origin used in v0 - origin).
- origin_2[2:0]  in  3x32 signed  write data for FIFO 1 (origin used in the final add).
- dir_1[2:0]  in  3x32 signed  write data for FIFO 2 (direction used in the denominator).
- dir_2[2:0]  in  3x32 signed  write data for FIFO 3 (direction scaled by t).
- in_wr_en[3:0]  in  4  per-FIFO write enables; index order 0..3 as above.
- in_full[3:0]  out  4  per-FIFO full flags.
- out[2:0]  out  3x32 signed  head of the output FIFO (Px, Py, Pz).
- out_rd_en  in  1  pops the output FIFO head.
- out_empty  out  1  output FIFO empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFOs are emptied and pipeline valid bits cleared.
  - in_full = 4'b0000, out_empty = 1, out = 0.
  - A reset mid-operation discards all in-flight and queued data.
- Input FIFOs:
  - Each FIFO writes on in_wr_en[i] && !in_full[i].
  - A write while full is dropped with no side effect.
  - All four FIFOs are written independently.
- Issue:
  - One operand set is popped from all four FIFOs in the same cycle when all four are non-empty AND (output FIFO count + in-flight count) < FIFO_DEPTH.
  - The pipeline itself never stalls.
  - Static inputs are sampled in the issue cycle.
- Pipeline (registered stages):
  - S1: d = v0 - origin_1, per component, 32-bit wrap.
  - S2: num = sum over k of (tri_normal_1[k]*d[k]) >>> Q_BITS; den = sum over k of (tri_normal_2[k]*dir_1[k]) >>> Q_BITS. Products are 64-bit signed; each product is arithmetically shifted before summing; sums are truncated to 32-bit signed.
  - S3: t = (num <<< Q_BITS) / den. Dividend is 48-bit signed; quotient truncates toward zero and is truncated to 32 bits. If den == 0, t = 0.
  - S4: P[k] = origin_2[k] + ((t*dir_2[k]) >>> Q_BITS), 32-bit wrap; P is written to the output FIFO.
- Latency: the result is visible on out with out_empty=0 at the 5th rising edge after the pop edge. Throughput is 1 result per cycle.
- Output FIFO:
  - Show-ahead: out shows the head whenever out_empty=0.
  - out_rd_en while empty is ignored.
  - Simultaneous write and read is allowed when non-empty; count is unchanged.
- Ordering: results are produced in strict input order; no reordering, no loss while credits are respected.

Decomposition:
- Package p_hit_pkg holds:
  - Q_BITS default and FIFO_DEPTH default.
  - typedef fixed_t (logic signed [31:0]) and typedef vec3_t (fixed_t [2:0]).
  - Fixed-point multiply helper function (64-bit product, >>> Q_BITS, truncate).
- One sub-module, p_hit_fifo: parameterized width and depth, show-ahead, async active-low reset. Instantiated 4 times with width 96 for the inputs and once for the output.
- Datapath stages live in p_hit.

Test Plan:
- Axis hit: n1=n2=(0,0,0x00010000), v0=(0,0,0x00050000), origins=(0,0,0), dirs=(0,0,0x00010000) -> out=(0,0,0x00050000), out_empty falls 5 edges after the pop.
- Oblique: same normals/v0, dirs=(0x00010000,0,0x00010000), origins=(0,0,0) -> t=5, out=(0x00050000,0,0x00050000).
- Parallel ray: dirs=(0x00010000,0,0), origin_2=(0x00020000,0x00030000,0) -> den=0, out=(0x00020000,0x00030000,0).
- Stream and backpressure: write 40 distinct rays with out_rd_en=0.
  - Output FIFO fills to 16.
  - All in_full assert after 16 more rays queue.
  - Later writes are dropped.
  - Then drain: the first 32 results are in order and match the model.
- Mismatched fill: write only FIFOs 0-2 -> no issue, out_empty stays 1. Then write FIFO 3 -> exactly one result.
- Reset mid-stream: assert reset with data queued and in flight -> out_empty=1, in_full=0 immediately. Post-reset traffic is correct, with no stale results.
